// File: rtl/npc_pkg.sv
// Shared NPC core definitions: reset PC, fault encoding, IFU state enum.
package npc_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  // IDU decodes an all-zero word as pc_op 0 (no-op / fault encoding).
  localparam logic [31:0] INST_NOP_FAULT   = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RSP,
    S_OUT,
    S_NPC
  } ifu_state_t;

  // Word fetches need a 4-byte aligned PC.
  function automatic logic pc_misaligned(input logic [31:0] pc);
    return |pc[1:0];
  endfunction

endpackage

// File: rtl/ifu_if.sv
// IFU bus bundle: imem request/response, IDU hand-off, write-back next PC.
interface ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_fault;
  logic        npc_valid;
  logic [31:0] npc;

  // IFU side
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output inst_valid, inst, inst_pc, fetch_fault,
    input  inst_ready,
    input  npc_valid, npc
  );

  // Memory / IDU / write-back side
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  inst_valid, inst, inst_pc, fetch_fault,
    output inst_ready,
    output npc_valid, npc
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one fetch per architectural step, then wait for npc.
module ifu
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic   clk,
  input logic   rst_n,
  ifu_if.master bus
);

  ifu_state_t  state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        fault_q;
  logic        mis;

  assign mis = pc_misaligned(pc_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; inputs outside their owning state are ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (mis)                      state_d = S_OUT;
        else if (bus.imem_req_ready)  state_d = S_RSP;
      end
      S_RSP:  if (bus.imem_rsp_valid) state_d = S_OUT;
      S_OUT:  if (bus.inst_ready)     state_d = S_NPC;
      S_NPC:  if (bus.npc_valid)      state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  // PC and instruction holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      inst_q    <= INST_NOP_FAULT;
      inst_pc_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: if (mis) begin
          inst_q    <= INST_NOP_FAULT;
          fault_q   <= 1'b1;
          inst_pc_q <= pc_q;
        end
        S_RSP: if (bus.imem_rsp_valid) begin
          inst_q    <= bus.imem_rsp_err ? INST_NOP_FAULT : bus.imem_rsp_data;
          fault_q   <= bus.imem_rsp_err;
          inst_pc_q <= pc_q;
        end
        S_NPC: if (bus.npc_valid) pc_q <= bus.npc;
        default: ;
      endcase
    end
  end

  // Outputs come straight from state and registers only
  assign bus.imem_req_valid = (state_q == S_REQ) && !mis;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = (state_q == S_OUT);
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.fetch_fault    = fault_q;

endmodule
